// File: rtl/xor_timing_pkg.sv
// ----------------------------------------------------------------------------
// xor_timing_pkg
//   Shared types and helpers for the XOR cell path-delay monitor.
//   - xmon_state_t : monitor FSM states
//   - arc_t        : classification of one measured timing arc
//   - arc_limit()  : maximum allowed delay (in cycles) for an arc class
// ----------------------------------------------------------------------------
package xor_timing_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      REPORT = 2'd2
   } xmon_state_t;

   // src : 0 = arc launched by input a, 1 = arc launched by input b
   // inv : 1 = the other input was 1, so the cell inverts the toggling input
   // rise: 1 = the expected output transition is 0->1
   typedef struct packed {
      logic src;
      logic inv;
      logic rise;
   } arc_t;

   // The source input does not affect the limit; only {inv, rise} selects it.
   function automatic int unsigned arc_limit(
      input arc_t        arc,
      input int unsigned noninv_rise,
      input int unsigned noninv_fall,
      input int unsigned inv_rise,
      input int unsigned inv_fall
   );
      int unsigned lim;
      casez (arc)
         3'b?01:  lim = noninv_rise;
         3'b?00:  lim = noninv_fall;
         3'b?11:  lim = inv_rise;
         default: lim = inv_fall;
      endcase
      return lim;
   endfunction

endpackage

// File: rtl/xor_edge_detect.sv
// ----------------------------------------------------------------------------
// xor_edge_detect
//   Registers the XOR cell pins once per cycle and flags which of them changed
//   since the previous cycle.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  synchronous active-high reset
//     a_i      in  cell input a (synchronous to clk)
//     b_i      in  cell input b (synchronous to clk)
//     out_i    in  cell output  (synchronous to clk)
//     a_tg_o   out a differs from its value on the previous cycle
//     b_tg_o   out b differs from its value on the previous cycle
//     out_tg_o out out differs from its value on the previous cycle
// ----------------------------------------------------------------------------
module xor_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic a_i,
   input  logic b_i,
   input  logic out_i,
   output logic a_tg_o,
   output logic b_tg_o,
   output logic out_tg_o
);

   logic a_q;
   logic b_q;
   logic out_q;
   logic armed_q;

   // NOTE: the history flops deliberately have no reset; they track the pins
   // even while rst is high so the first post-reset compare is against real
   // pin values rather than a reset constant.
   always_ff @(posedge clk) begin
      a_q   <= a_i;
      b_q   <= b_i;
      out_q <= out_i;
   end

   // Suppresses every event on the first cycle after reset.
   always_ff @(posedge clk) begin
      if (rst) armed_q <= 1'b0;
      else     armed_q <= 1'b1;
   end

   assign a_tg_o   = armed_q & (a_i   ^ a_q);
   assign b_tg_o   = armed_q & (b_i   ^ b_q);
   assign out_tg_o = armed_q & (out_i ^ out_q);

endmodule

// File: rtl/xor_path_delay_monitor.sv
// ----------------------------------------------------------------------------
// xor_path_delay_monitor
//   Measures the conditional pin-to-pin delay of a 2-input XOR cell. Each
//   single-input toggle starts a measurement; the number of cycles until
//   out == a^b is reported together with the arc class and a limit check.
//   Ports:
//     clk         in  clock, rising edge
//     rst         in  synchronous active-high reset
//     a, b        in  cell inputs (synchronous to clk)
//     out         in  cell output (synchronous to clk)
//     meas_valid  out one-cycle pulse, meas_* fields valid
//     meas_src    out 0 = arc from a, 1 = arc from b
//     meas_inv    out 1 = inverting arc (other input was 1)
//     meas_rise   out 1 = expected out transition 0->1
//     meas_delay  out cycles from input toggle to settle (min 1)
//     viol        out with meas_valid: delay exceeded the arc limit
//     timeout     out one-cycle pulse, out never settled within TIMEOUT
//     spurious    out one-cycle pulse, out moved while idle with stable inputs
//     abort_cnt   out saturating count of measurements restarted by a toggle
// ----------------------------------------------------------------------------
module xor_path_delay_monitor
   import xor_timing_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned NONINV_RISE = 1,
   parameter int unsigned NONINV_FALL = 2,
   parameter int unsigned INV_RISE    = 3,
   parameter int unsigned INV_FALL    = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             out,
   output logic             meas_valid,
   output logic             meas_src,
   output logic             meas_inv,
   output logic             meas_rise,
   output logic [CNT_W-1:0] meas_delay,
   output logic             viol,
   output logic             timeout,
   output logic             spurious,
   output logic [CNT_W-1:0] abort_cnt
);

   logic a_tg;
   logic b_tg;
   logic out_tg;
   logic one_tg;
   logic any_tg;
   logic settled;
   arc_t new_arc;

   xmon_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   arc_t             arc_q, arc_d;
   arc_t             meas_arc_q, meas_arc_d;
   logic [CNT_W-1:0] meas_delay_q, meas_delay_d;
   logic             meas_valid_q, meas_valid_d;
   logic             viol_q, viol_d;
   logic             timeout_q, timeout_d;
   logic             spurious_q, spurious_d;
   logic [CNT_W-1:0] abort_q, abort_d;

   xor_edge_detect u_edge (
      .clk      (clk),
      .rst      (rst),
      .a_i      (a),
      .b_i      (b),
      .out_i    (out),
      .a_tg_o   (a_tg),
      .b_tg_o   (b_tg),
      .out_tg_o (out_tg)
   );

   // A simultaneous toggle of both inputs leaves a^b unchanged, so it is not
   // an arc and never starts a measurement.
   assign one_tg  = a_tg ^ b_tg;
   assign any_tg  = a_tg | b_tg;
   assign settled = (out == (a ^ b));
   // The "other" input is the one that did not toggle.
   assign new_arc = {b_tg, (b_tg ? a : b), (a ^ b)};

   // NOTE: every variable of this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      arc_d        = arc_q;
      meas_arc_d   = meas_arc_q;
      meas_delay_d = meas_delay_q;
      abort_d      = abort_q;
      meas_valid_d = 1'b0;
      viol_d       = 1'b0;
      timeout_d    = 1'b0;
      spurious_d   = 1'b0;

      unique case (state_q)
         IDLE, REPORT: begin
            // REPORT lasts one cycle; a toggle arriving in it is captured
            // exactly as in IDLE so no event is lost.
            state_d = IDLE;
            if (one_tg) begin
               state_d = WAIT;
               arc_d   = new_arc;
               cnt_d   = CNT_W'(1);
            end else if (state_q == IDLE && !any_tg && out_tg) begin
               spurious_d = 1'b1;
            end
         end

         WAIT: begin
            if (any_tg) begin
               // An input moved before out settled: the old arc is abandoned.
               abort_d = (abort_q == '1) ? abort_q : abort_q + 1'b1;
               if (one_tg) begin
                  arc_d = new_arc;
                  cnt_d = CNT_W'(1);
               end else begin
                  state_d = IDLE;
               end
            end else if (settled) begin
               state_d      = REPORT;
               meas_valid_d = 1'b1;
               meas_arc_d   = arc_q;
               meas_delay_d = cnt_q;
               viol_d       = 32'(cnt_q) > arc_limit(arc_q, NONINV_RISE, NONINV_FALL,
                                                     INV_RISE, INV_FALL);
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         arc_q        <= '0;
         meas_arc_q   <= '0;
         meas_delay_q <= '0;
         meas_valid_q <= 1'b0;
         viol_q       <= 1'b0;
         timeout_q    <= 1'b0;
         spurious_q   <= 1'b0;
         abort_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         arc_q        <= arc_d;
         meas_arc_q   <= meas_arc_d;
         meas_delay_q <= meas_delay_d;
         meas_valid_q <= meas_valid_d;
         viol_q       <= viol_d;
         timeout_q    <= timeout_d;
         spurious_q   <= spurious_d;
         abort_q      <= abort_d;
      end
   end

   assign meas_valid = meas_valid_q;
   assign meas_src   = meas_arc_q.src;
   assign meas_inv   = meas_arc_q.inv;
   assign meas_rise  = meas_arc_q.rise;
   assign meas_delay = meas_delay_q;
   assign viol       = viol_q;
   assign timeout    = timeout_q;
   assign spurious   = spurious_q;
   assign abort_cnt  = abort_q;

endmodule

// File: tb/tb_xor_path_delay_monitor.sv
// ----------------------------------------------------------------------------
// tb_xor_path_delay_monitor
//   Self-checking bench for xor_path_delay_monitor: a table of directed
//   vectors, hand-written timeout/reset sequences and a randomized run, all
//   also compared every cycle against a timestamp-based reference model.
// ----------------------------------------------------------------------------
module tb_xor_path_delay_monitor;

   localparam int unsigned TIMEOUT = 255;

   logic       clk;
   logic       rst;
   logic       a;
   logic       b;
   logic       out_s;
   logic       meas_valid;
   logic       meas_src;
   logic       meas_inv;
   logic       meas_rise;
   logic [7:0] meas_delay;
   logic       viol;
   logic       timeout;
   logic       spurious;
   logic [7:0] abort_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   xor_path_delay_monitor #(
      .CNT_W       (8),
      .NONINV_RISE (1),
      .NONINV_FALL (2),
      .INV_RISE    (3),
      .INV_FALL    (4),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a          (a),
      .b          (b),
      .out        (out_s),
      .meas_valid (meas_valid),
      .meas_src   (meas_src),
      .meas_inv   (meas_inv),
      .meas_rise  (meas_rise),
      .meas_delay (meas_delay),
      .viol       (viol),
      .timeout    (timeout),
      .spurious   (spurious),
      .abort_cnt  (abort_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector layout: {valid, src, inv, rise, delay[7:0], viol, timeout,
   // spurious, abort[7:0]}
   function automatic logic [22:0] pack(input bit v, input bit s, input bit i, input bit r,
                                        input int d, input bit vl, input bit t,
                                        input bit sp, input int ab);
      return {v, s, i, r, 8'(d), vl, t, sp, 8'(ab)};
   endfunction

   function automatic logic [22:0] dut_vec();
      return {meas_valid, meas_src, meas_inv, meas_rise, meas_delay,
              viol, timeout, spurious, abort_cnt};
   endfunction

   task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: a measurement is a timestamp of the launching toggle;
   // its delay is simply the cycle number of the settle minus that stamp.
   // ------------------------------------------------------------------------
   int  cyc = 0;
   bit  m_armed, pa, pb, po;
   bit  m_pend, m_src, m_inv, m_rise, m_prev_valid;
   int  m_t0;
   bit  e_valid, e_src, e_inv, e_rise, e_viol, e_to, e_sp;
   int  e_delay, e_abort;

   function automatic int limit_of(input bit inv, input bit rise);
      if (inv) return rise ? 3 : 4;
      return rise ? 1 : 2;
   endfunction

   function automatic void m_start(input bit ib_tg, input bit ia, input bit ib);
      m_pend = 1'b1;
      m_t0   = cyc;
      m_src  = ib_tg;
      m_inv  = ib_tg ? ia : ib;
      m_rise = ia ^ ib;
   endfunction

   function automatic void model_update(input bit r, input bit ia, input bit ib, input bit io);
      bit ta, tb, to;
      cyc++;
      e_valid = 0; e_viol = 0; e_to = 0; e_sp = 0;
      if (r) begin
         m_armed = 0; m_pend = 0;
         e_src = 0; e_inv = 0; e_rise = 0; e_delay = 0; e_abort = 0;
      end else begin
         ta = m_armed && (ia != pa);
         tb = m_armed && (ib != pb);
         to = m_armed && (io != po);
         if (m_pend) begin
            if (ta || tb) begin
               e_abort = (e_abort < 255) ? e_abort + 1 : 255;
               if (ta != tb) m_start(tb, ia, ib);
               else          m_pend = 0;
            end else if (io == (ia ^ ib)) begin
               e_valid = 1; e_src = m_src; e_inv = m_inv; e_rise = m_rise;
               e_delay = cyc - m_t0;
               e_viol  = (cyc - m_t0) > limit_of(m_inv, m_rise);
               m_pend  = 0;
            end else if (cyc - m_t0 >= int'(TIMEOUT)) begin
               e_to   = 1;
               m_pend = 0;
            end
         end else begin
            if (ta != tb) m_start(tb, ia, ib);
            else if (!ta && !tb && to && !m_prev_valid) e_sp = 1;
         end
         m_armed = 1;
      end
      m_prev_valid = e_valid;
      pa = ia; pb = ib; po = io;
   endfunction

   function automatic logic [22:0] exp_vec();
      return pack(e_valid, e_src, e_inv, e_rise, e_delay, e_viol, e_to, e_sp, e_abort);
   endfunction

   // One clock: drive pins, let the DUT sample, advance the model, compare.
   task automatic step(input bit r, input bit ia, input bit ib, input bit io);
      rst = r; a = ia; b = ib; out_s = io;
      @(posedge clk);
      model_update(r, ia, ib, io);
      #1;
      check("model", dut_vec(), exp_vec());
   endtask

   // ------------------------------------------------------------------------
   typedef struct {
      bit          r, a, b, o;
      logic [22:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic void row(input bit r, input bit ia, input bit ib, input bit io,
                               input bit v, input bit s, input bit i, input bit rs,
                               input int d, input bit vl, input bit t, input bit sp,
                               input int ab);
      vec_t x;
      x.r = r; x.a = ia; x.b = ib; x.o = io;
      x.exp = pack(v, s, i, rs, d, vl, t, sp, ab);
      vecs.push_back(x);
   endfunction

   initial begin
      bit early;
      bit ra, rb, ro;

      // Non-inverting rise, settles after one cycle.
      row(1,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,0,1, 1,0,0,1,1,0,0,0,0);
      row(0,1,0,1, 0,0,0,1,1,0,0,0,0);
      // Inverting fall, settles after five cycles: over the limit of 4.
      row(1,0,1,1, 0,0,0,0,0,0,0,0,0);
      row(0,0,1,1, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,1, 0,0,0,0,0,0,0,0,0);
      for (int k = 0; k < 4; k++) row(0,1,1,1, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,0, 1,0,1,0,5,1,0,0,0);
      row(0,1,1,0, 0,0,1,0,5,0,0,0,0);
      // b toggles, a toggles two cycles later: one abort, one record.
      row(1,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,0,1,0, 0,0,0,0,0,0,0,0,0);
      row(0,0,1,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,0, 0,0,0,0,0,0,0,0,1);
      row(0,1,1,0, 1,0,1,0,1,0,0,0,1);
      row(0,1,1,0, 0,0,1,0,1,0,0,0,1);
      // Both inputs together: no record; a later lone out toggle is spurious.
      row(1,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,0,0,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,0, 0,0,0,0,0,0,0,0,0);
      row(0,1,1,1, 0,0,0,0,0,0,0,1,0);
      row(0,1,1,1, 0,0,0,0,0,0,0,0,0);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].o);
         check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
      end

      // Timeout: out never follows a rising a.
      step(1,0,0,0);
      step(0,0,0,0);
      step(0,1,0,0);
      early = 1'b0;
      for (int k = 1; k < int'(TIMEOUT); k++) begin
         step(0,1,0,0);
         if (timeout || meas_valid) early = 1'b1;
      end
      check("timeout_early", 23'(early), 23'(0));
      step(0,1,0,0);
      check("timeout_pulse", {meas_valid, timeout}, 23'(2'b01));
      step(0,1,0,0);
      check("timeout_clear", 23'(timeout), 23'(0));
      step(0,1,0,1);
      check("idle_after_timeout", 23'(spurious), 23'(1));

      // Reset during WAIT drops the measurement; the next arc is measured.
      step(1,0,0,0);
      step(0,0,0,0);
      step(0,1,0,0);
      step(0,1,0,0);
      step(1,1,0,1);
      check("rst_mid_wait", dut_vec(), 23'(0));
      step(0,1,0,1);
      check("post_rst_quiet", dut_vec(), 23'(0));
      step(0,1,0,1);
      check("post_rst_quiet2", dut_vec(), 23'(0));
      step(0,1,1,1);
      step(0,1,1,0);
      check("post_rst_meas", dut_vec(), pack(1,1,1,0,1,0,0,0,0));

      // Randomized run against the model.
      ra = 0; rb = 0; ro = 0;
      step(1,0,0,0);
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(9) == 0) ra = ~ra;
         if ($urandom_range(9) == 0) rb = ~rb;
         if ($urandom_range(3) == 0)       ro = ra ^ rb;
         else if ($urandom_range(31) == 0) ro = ~ro;
         step(($urandom_range(255) == 0), ra, rb, ro);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
